mdu_unit: RTL and testbench

- Multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- It is the successor to the single-cycle core: MULT/MULTU/DIV/DIVU run over a parametrised number of busy cycles, and MFHI/MFLO/MTHI/MTLO are supported.
- Sits in the EX stage. The hazard logic stalls the pipeline on `stall`.

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_if.sv | 28 ++
 rtl/mdu_arith.sv | 69 ++++++
 rtl/mdu_unit.sv | 102 ++++++++++
 tb/tb_mdu_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   mdu_op_t     - 4-bit MD operation encoding presented on the op port
//   state_t      - IDLE/RUN control state
//   DEF_*        - default width and latencies
//   is_md_start  - true for the ops that start a multi-cycle operation
package mdu_pkg;

  localparam int OP_W            = 4;
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

  typedef enum logic [OP_W-1:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_md_start(mdu_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_mult(mdu_op_t op);
    return (op == MULT) || (op == MULTU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> MDU bus.
//   master (EX stage): drives valid/op/a/b, observes busy/stall/hi/lo/rdata
//   slave  (mdu_unit): the reverse
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             valid;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;

  modport master (
    output valid, op, a, b,
    input  busy, stall, hi, lo, rdata
  );

  modport slave (
    input  valid, op, a, b,
    output busy, stall, hi, lo, rdata
  );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for MULT/MULTU/DIV/DIVU.
//   op            - operation (non-arithmetic ops give zero)
//   a, b          - rs / rt operands
//   res_hi/res_lo - value destined for HI/LO when the operation retires
// Divide by zero yields lo = all ones, hi = a. The one signed overflow
// case (most-negative / -1) yields lo = a, hi = 0.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               div0, ovf;
  logic [WIDTH-1:0]   b_safe;
  logic signed [WIDTH-1:0] quo_s, rem_s;

  // Operands are widened to 2*WIDTH so the product keeps every bit.
  assign prod_s = $unsigned($signed({{WIDTH{a[WIDTH-1]}}, a}) *
                            $signed({{WIDTH{b[WIDTH-1]}}, b}));
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign div0   = (b == '0);
  assign ovf    = (a == MOST_NEG) && (b == '1);
  // Keeps the divider datapath defined when b==0; the result is overridden.
  assign b_safe = div0 ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign quo_s  = $signed(a) / $signed(b_safe);
  assign rem_s  = $signed(a) % $signed(b_safe);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MULT:  {res_hi, res_lo} = prod_s;
      MULTU: {res_hi, res_lo} = prod_u;
      DIV: begin
        if (div0) begin
          res_hi = a;
          res_lo = '1;
        end else if (ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          res_hi = $unsigned(rem_s);
          res_lo = $unsigned(quo_s);
        end
      end
      DIVU: begin
        if (div0) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = a % b_safe;
          res_lo = a / b_safe;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO for the EX stage.
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-low
//   bus    - mdu_if.slave: valid/op/a/b in; busy/stall/hi/lo/rdata out
// The result is computed at the issue edge and parked in res_hi/res_lo;
// HI/LO only change when the countdown retires, so a reset during RUN
// discards it. Any op presented while busy is ignored; the stall output
// makes the pipeline hold it until busy drops.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] ar_hi, ar_lo;
  logic             busy, accept;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .res_hi (ar_hi),
    .res_lo (ar_lo)
  );

  assign busy   = (state_q == RUN);
  assign accept = bus.valid && !busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_md_start(bus.op)) begin
            state_d  = RUN;
            cnt_d    = is_mult(bus.op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            res_hi_d = ar_hi;
            res_lo_d = ar_lo;
          end else if (bus.op == MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      RUN: begin
        // Counter was loaded with N at issue, so busy spans exactly N cycles.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = busy;
  assign bus.stall = busy || (bus.valid && (bus.op != NONE));
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.rdata = (bus.op == MFHI) ? hi_q :
                     (bus.op == MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: two instances driven by the same stimulus, one with the
// default latencies (5/10) and one with 1/1, checked against hand-derived
// vectors and an arithmetic reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  mdu_op_t     op;
  logic [31:0] a, b;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_if #(.WIDTH(32)) bus0 ();
  mdu_if #(.WIDTH(32)) bus1 ();

  assign bus0.valid = valid;
  assign bus0.op    = op;
  assign bus0.a     = a;
  assign bus0.b     = b;
  assign bus1.valid = valid;
  assign bus1.op    = op;
  assign bus1.a     = a;
  assign bus1.b     = b;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) u0 (
    .clk(clk), .reset(rst_n), .bus(bus0));
  mdu_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from the architectural definition.
  function automatic logic [63:0] model(mdu_op_t o, logic [31:0] x, logic [31:0] y);
    int     sx, sy;
    longint p;
    sx = x;
    sy = y;
    case (o)
      MULT: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      MULTU: return {32'd0, x} * {32'd0, y};
      DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int lat0(mdu_op_t o);
    return (o == MULT || o == MULTU) ? 5 : 10;
  endfunction

  task automatic idle_inputs();
    valid = 1'b0;
    op    = NONE;
    a     = '0;
    b     = '0;
  endtask

  // Issue one arithmetic op, count busy cycles on both units, check stall.
  task automatic run_op(string name, mdu_op_t o, logic [31:0] x, logic [31:0] y,
                        logic [31:0] ehi, logic [31:0] elo);
    int c0, c1, bad;
    valid = 1'b1; op = o; a = x; b = y;
    #1;
    chk({name, "_issue_stall0"}, 32'(bus0.stall), 32'd1);
    chk({name, "_issue_stall1"}, 32'(bus1.stall), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    c0 = 0; c1 = 0; bad = 0;
    for (int k = 0; k < 40 && (bus0.busy || bus1.busy); k++) begin
      if (bus0.busy) c0++;
      if (bus1.busy) c1++;
      if (bus0.stall !== bus0.busy || bus1.stall !== bus1.busy) bad++;
      @(posedge clk); #2;
    end
    chk({name, "_busy_cycles0"}, 32'(c0), 32'(lat0(o)));
    chk({name, "_busy_cycles1"}, 32'(c1), 32'd1);
    chk({name, "_stall_track"},  32'(bad), 32'd0);
    chk({name, "_stall_low"},    32'(bus0.stall | bus1.stall), 32'd0);
    chk({name, "_hi0"}, bus0.hi, ehi);
    chk({name, "_lo0"}, bus0.lo, elo);
    chk({name, "_hi1"}, bus1.hi, ehi);
    chk({name, "_lo1"}, bus1.lo, elo);
  endtask

  // MT then MF in the following cycle.
  task automatic mt_mf(string name, logic to_hi, logic [31:0] v);
    valid = 1'b1; op = to_hi ? MTHI : MTLO; a = v;
    @(posedge clk); #1;
    chk({name, "_mt_nobusy"}, 32'(bus0.busy | bus1.busy), 32'd0);
    op = to_hi ? MFHI : MFLO; a = '0;
    #1;
    chk({name, "_mf_rdata0"}, bus0.rdata, v);
    chk({name, "_mf_rdata1"}, bus1.rdata, v);
    chk({name, "_mf_stall"},  32'(bus0.stall), 32'd1);
    idle_inputs();
    #1;
    chk({name, "_none_rdata"}, bus0.rdata, 32'd0);
  endtask

  typedef struct {
    string       name;
    mdu_op_t     op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb;
    mdu_op_t     ro;
    logic [31:0] keep_hi, keep_lo;

    vecs.push_back('{"mult_neg",  MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{"multu",     MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{"div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_zero", DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{"div_zero",  DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"divu_big",  DIVU,  32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC});
    vecs.push_back('{"mult_mneg", MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    vecs.push_back('{"div_negb",  DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi0", bus0.hi, 32'd0);
    chk("rst_lo0", bus0.lo, 32'd0);
    chk("rst_busy0", 32'(bus0.busy), 32'd0);
    chk("rst_stall0", 32'(bus0.stall), 32'd0);
    chk("rst_hi1", bus1.hi, 32'd0);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // MTHI during busy is dropped; the same op after busy falls lands.
    valid = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    op = MTHI; a = 32'h1234;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < 40 && bus0.busy; k++) begin
      @(posedge clk); #1;
    end
    chk("mthi_busy_hi0", bus0.hi, 32'd2);
    chk("mthi_busy_lo0", bus0.lo, 32'd14);
    chk("mthi_busy_hi1", bus1.hi, 32'd2);
    mt_mf("mthi_after", 1'b1, 32'h1234);
    mt_mf("mtlo_after", 1'b0, 32'hCAFE_0001);

    for (int it = 0; it < 30; it++) begin
      ro = mdu_op_t'(OP_W'($urandom_range(1, 4)));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      m = model(ro, ra, rb);
      run_op($sformatf("rnd%0d", it), ro, ra, rb, m[63:32], m[31:0]);
      if (it % 6 == 5) mt_mf($sformatf("rndmt%0d", it), it[0], $urandom);
    end

    // Reset in the 4th busy cycle of a DIV aborts it and clears HI/LO.
    mt_mf("pre_rst", 1'b1, 32'h5555_AAAA);
    keep_hi = bus0.hi;
    keep_lo = bus0.lo;
    valid = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_still_busy", 32'(bus0.busy), 32'd1);
    chk("midrst_hi_kept", bus0.hi, keep_hi);
    chk("midrst_lo_kept", bus0.lo, keep_lo);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(bus0.busy), 32'd0);
    chk("midrst_stall", 32'(bus0.stall), 32'd0);
    chk("midrst_hi", bus0.hi, 32'd0);
    chk("midrst_lo", bus0.lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_result_hi", bus0.hi, 32'd0);
    chk("midrst_no_result_lo", bus0.lo, 32'd0);
    chk("midrst_idle", 32'(bus0.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
